// File: rtl/dmem_ctrl.sv
// dmem_ctrl: fixed-latency data-memory controller between the core MEM port and a 64-bit sync RAM.
// Optional request checking (range/alignment -> bus_error) is built when DMEM_ERR_CHECK_EN is defined.
module dmem_ctrl #(
    parameter int unsigned RAM_AW       = 12,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [63:0] BASE_ADDR    = 64'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [63:0]       data_mem_addr,
    input  logic              data_mem_addr_valid,
    input  logic              data_mem_rw,
    input  logic [63:0]       data_mem_data_w,
    input  logic [7:0]        data_mem_byte_en,
    output logic [63:0]       data_mem_data_r,
    output logic              data_mem_ready,
    output logic              bus_error,
    output logic              ram_en,
    output logic [7:0]        ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [63:0]       ram_wdata,
    input  logic [63:0]       ram_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WAIT,
        RESP
    } state_t;

    state_t            state_q;
    logic [2:0]        cnt_q;
    logic              rw_q;
    logic [63:0]       data_r_q;
    logic              ready_q;
    logic              bus_err_q;
    logic              ram_en_q;
    logic [7:0]        ram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [63:0]       ram_wdata_q;

    // Byte offset from the RAM base; wraps below BASE_ADDR.
    logic [63:0]       offs_d;
    logic [RAM_AW-1:0] word_d;
    logic              req_err_d;
    logic              unused_offs;

    assign offs_d      = data_mem_addr - BASE_ADDR;
    assign word_d      = offs_d[RAM_AW+2:3];
    assign unused_offs = ^{offs_d[63:RAM_AW+3], offs_d[2:0]};

`ifdef DMEM_ERR_CHECK_EN
    // One past the last mapped byte, kept 65 bits wide so it cannot wrap.
    localparam logic [64:0] LIMIT = {1'b0, BASE_ADDR} + (65'd8 << RAM_AW);

    logic below_d;
    logic above_d;
    logic misal_d;

    assign below_d   = data_mem_addr < BASE_ADDR;
    assign above_d   = {1'b0, data_mem_addr} >= LIMIT;
    assign misal_d   = (data_mem_addr[2:0] != 3'd0) &&
                       (data_mem_byte_en == 8'hFF);
    assign req_err_d = below_d | above_d | misal_d;
`else
    assign req_err_d = 1'b0;
`endif

    // Request FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= 3'd0;
            rw_q        <= 1'b0;
            data_r_q    <= 64'h0;
            ready_q     <= 1'b0;
            bus_err_q   <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 8'h0;
            ram_addr_q  <= '0;
            ram_wdata_q <= 64'h0;
        end else begin
            ready_q   <= 1'b0;
            bus_err_q <= 1'b0;
            ram_en_q  <= 1'b0;
            ram_we_q  <= 8'h0;
            unique case (state_q)
                IDLE: begin
                    if (data_mem_addr_valid) begin
                        if (req_err_d) begin
                            // Rejected: answer next cycle, RAM untouched.
                            state_q   <= RESP;
                            ready_q   <= 1'b1;
                            bus_err_q <= 1'b1;
                        end else begin
                            state_q    <= ACCESS;
                            rw_q       <= data_mem_rw;
                            ram_en_q   <= 1'b1;
                            ram_addr_q <= word_d;
                            if (data_mem_rw) begin
                                ram_we_q    <= data_mem_byte_en;
                                ram_wdata_q <= data_mem_data_w;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (rw_q) begin
                        state_q <= RESP;
                        ready_q <= 1'b1;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= 3'(READ_LATENCY);
                    end
                end
                WAIT: begin
                    // Last WAIT cycle is when the RAM data is valid.
                    if (cnt_q <= 3'd1) begin
                        cnt_q    <= 3'd0;
                        state_q  <= RESP;
                        ready_q  <= 1'b1;
                        data_r_q <= ram_rdata;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_mem_data_r = data_r_q;
    assign data_mem_ready  = ready_q;
    assign bus_error       = bus_err_q;
    assign ram_en          = ram_en_q;
    assign ram_we          = ram_we_q;
    assign ram_addr        = ram_addr_q;
    assign ram_wdata       = ram_wdata_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// tb_dmem_ctrl: directed bench for dmem_ctrl with a 1-cycle synchronous RAM model.
// Build with DMEM_ERR_CHECK_EN defined to exercise the rejection path.
module tb_dmem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] addr;
    logic        valid;
    logic        rw;
    logic [63:0] wdat;
    logic [7:0]  be;
    logic [63:0] data_r;
    logic        ready;
    logic        berr;
    logic        ram_en;
    logic [7:0]  ram_we;
    logic [11:0] ram_addr;
    logic [63:0] ram_wdata;
    logic [63:0] ram_rdata;

    int checks   = 0;
    int failures = 0;

    logic [63:0] mem [0:4095];

    always #5 clk = ~clk;

    dmem_ctrl #(
        .RAM_AW      (12),
        .READ_LATENCY(1),
        .BASE_ADDR   (64'h0)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .data_mem_addr      (addr),
        .data_mem_addr_valid(valid),
        .data_mem_rw        (rw),
        .data_mem_data_w    (wdat),
        .data_mem_byte_en   (be),
        .data_mem_data_r    (data_r),
        .data_mem_ready     (ready),
        .bus_error          (berr),
        .ram_en             (ram_en),
        .ram_we             (ram_we),
        .ram_addr           (ram_addr),
        .ram_wdata          (ram_wdata),
        .ram_rdata          (ram_rdata)
    );

    // Synchronous RAM, one cycle read latency, byte-write enables.
    always @(posedge clk) begin
        if (ram_en) begin
            for (int b = 0; b < 8; b++)
                if (ram_we[b])
                    mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic w,
                         input logic [63:0] d, input logic [7:0] e);
        addr  = a;
        rw    = w;
        wdat  = d;
        be    = e;
        valid = 1'b1;
    endtask

    task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] e);
        drive(a, 1'b1, d, e);
        tick();
        valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic do_read(input logic [63:0] a, output logic [63:0] d);
        drive(a, 1'b0, 64'h0, 8'hFF);
        tick();
        valid = 1'b0;
        tick();
        tick();
        d = data_r;
        tick();
    endtask

    logic [63:0] rd;
    int          n_rdy;
    int          n_en;
    int          first_rdy;
    int          last_rdy;

    initial begin
        rst   = 1'b1;
        valid = 1'b0;
        addr  = 64'h0;
        rw    = 1'b0;
        wdat  = 64'h0;
        be    = 8'hFF;
        tick();
        tick();
        chk("rst_ready", {63'h0, ready}, 64'h0);
        chk("rst_berr", {63'h0, berr}, 64'h0);
        chk("rst_en", {63'h0, ram_en}, 64'h0);
        chk("rst_we", {56'h0, ram_we}, 64'h0);
        chk("rst_data_r", data_r, 64'h0);
        chk("rst_addr", {52'h0, ram_addr}, 64'h0);
        chk("rst_wdata", ram_wdata, 64'h0);
        rst = 1'b0;
        tick();

        // Full write to byte 0x10 (word 2).
        drive(64'h10, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        tick();
        chk("wr_en", {63'h0, ram_en}, 64'h1);
        chk("wr_we", {56'h0, ram_we}, 64'hFF);
        chk("wr_addr", {52'h0, ram_addr}, 64'h2);
        chk("wr_wdata", ram_wdata, 64'hDEAD_BEEF_0123_4567);
        chk("wr_t1_ready", {63'h0, ready}, 64'h0);
        valid = 1'b0;
        tick();
        chk("wr_t2_ready", {63'h0, ready}, 64'h1);
        chk("wr_t2_berr", {63'h0, berr}, 64'h0);
        chk("wr_t2_en", {63'h0, ram_en}, 64'h0);
        chk("wr_data_r_kept", data_r, 64'h0);
        tick();
        chk("wr_t3_ready", {63'h0, ready}, 64'h0);

        // Read it back with latency 1: ready at T+3.
        drive(64'h10, 1'b0, 64'h0, 8'hFF);
        tick();
        chk("rd_en", {63'h0, ram_en}, 64'h1);
        chk("rd_we", {56'h0, ram_we}, 64'h0);
        valid = 1'b0;
        tick();
        chk("rd_t2_ready", {63'h0, ready}, 64'h0);
        chk("rd_t2_en", {63'h0, ram_en}, 64'h0);
        tick();
        chk("rd_t3_ready", {63'h0, ready}, 64'h1);
        chk("rd_t3_data", data_r, 64'hDEAD_BEEF_0123_4567);
        tick();
        chk("rd_t4_ready", {63'h0, ready}, 64'h0);
        chk("rd_t4_hold", data_r, 64'hDEAD_BEEF_0123_4567);

        // Partial store over an all-ones word.
        do_write(64'h20, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_write(64'h20, 64'h0, 8'h0F);
        do_read(64'h20, rd);
        chk("partial", rd, 64'hFFFF_FFFF_0000_0000);

        // Back-to-back reads with valid held: pulses at 3, 7, 11.
        n_rdy     = 0;
        n_en      = 0;
        first_rdy = -1;
        last_rdy  = -1;
        drive(64'h10, 1'b0, 64'h0, 8'hFF);
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (ready) begin
                n_rdy++;
                if (first_rdy < 0) first_rdy = c;
                last_rdy = c;
            end
            if (ram_en) n_en++;
        end
        valid = 1'b0;
        chk("b2b_pulses", 64'(n_rdy), 64'd3);
        chk("b2b_en", 64'(n_en), 64'd3);
        chk("b2b_first", 64'(first_rdy), 64'd3);
        chk("b2b_last", 64'(last_rdy), 64'd11);
        chk("b2b_data", data_r, 64'hDEAD_BEEF_0123_4567);
        tick();
        tick();

        // Reset while in WAIT.
        drive(64'h20, 1'b0, 64'h0, 8'hFF);
        tick();
        valid = 1'b0;
        tick();
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_data", data_r, 64'h0);
        chk("mid_rst_ready", {63'h0, ready}, 64'h0);
        chk("mid_rst_addr", {52'h0, ram_addr}, 64'h0);
        tick();
        rst   = 1'b0;
        n_rdy = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (ready) n_rdy++;
        end
        chk("mid_rst_no_pulse", 64'(n_rdy), 64'd0);
        chk("mid_rst_data_hold", data_r, 64'h0);
        drive(64'h10, 1'b0, 64'h0, 8'hFF);
        tick();
        valid = 1'b0;
        tick();
        tick();
        chk("post_rst_ready", {63'h0, ready}, 64'h1);
        chk("post_rst_data", data_r, 64'hDEAD_BEEF_0123_4567);
        tick();

        do_write(64'h0, 64'h1111_2222_3333_4444, 8'hFF);

        // Misaligned full-width access, then one past the end.
`ifdef DMEM_ERR_CHECK_EN
        drive(64'h3, 1'b0, 64'h0, 8'hFF);
        tick();
        chk("mis_ready", {63'h0, ready}, 64'h1);
        chk("mis_berr", {63'h0, berr}, 64'h1);
        chk("mis_en", {63'h0, ram_en}, 64'h0);
        chk("mis_data", data_r, 64'hDEAD_BEEF_0123_4567);
        valid = 1'b0;
        tick();
        chk("mis_t2_ready", {63'h0, ready}, 64'h0);
        chk("mis_t2_berr", {63'h0, berr}, 64'h0);
        chk("mis_t2_en", {63'h0, ram_en}, 64'h0);
        drive(64'h8000, 1'b1, 64'h5555, 8'hFF);
        tick();
        chk("oor_ready", {63'h0, ready}, 64'h1);
        chk("oor_berr", {63'h0, berr}, 64'h1);
        chk("oor_en", {63'h0, ram_en}, 64'h0);
        valid = 1'b0;
        tick();
        chk("oor_t2_en", {63'h0, ram_en}, 64'h0);
        do_read(64'h0, rd);
        chk("oor_no_write", rd, 64'h1111_2222_3333_4444);
`else
        drive(64'h3, 1'b0, 64'h0, 8'hFF);
        tick();
        chk("mis_en", {63'h0, ram_en}, 64'h1);
        chk("mis_addr", {52'h0, ram_addr}, 64'h0);
        valid = 1'b0;
        tick();
        tick();
        chk("mis_ready", {63'h0, ready}, 64'h1);
        chk("mis_berr", {63'h0, berr}, 64'h0);
        chk("mis_data", data_r, 64'h1111_2222_3333_4444);
        tick();
        do_write(64'h10, 64'h0, 8'hFF);
        drive(64'h8010, 1'b0, 64'h0, 8'hFF);
        tick();
        chk("wrap_addr", {52'h0, ram_addr}, 64'h2);
        valid = 1'b0;
        tick();
        tick();
        chk("wrap_berr", {63'h0, berr}, 64'h0);
        chk("wrap_data", data_r, 64'h0);
        tick();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
